// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter and its
// alignment checker.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} mem_owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_align_check.sv
// Natural-alignment check for one memory access; fetches are always words and
// the reserved size encoding is treated as misaligned.
module mem_align_check
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [1:0] size,
    input  logic       is_fetch,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        if (is_fetch) begin
            misaligned = (addr_lo != 2'b00);
        end else begin
            case (size)
                SIZE_BYTE: misaligned = 1'b0;
                SIZE_HALF: misaligned = addr_lo[0];
                SIZE_WORD: misaligned = (addr_lo != 2'b00);
                default:   misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access,
// granting one request per cycle and routing the next-cycle response back.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    output logic              if_rsp_fault,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic [31:0]       mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_fault
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    mem_owner_t owner;
    logic [3:0] starve_cnt;
    logic       is_write_q;
    logic       fault_q;

    logic       force_if;
    logic       if_grant;
    logic       d_grant;
    logic       misaligned;
    logic       bad_req;

    // Data normally wins; a fetch that has waited out the limit takes the slot.
    assign force_if = if_valid && (starve_cnt == LIMIT);
    assign d_grant  = !rst && d_valid && !force_if;
    assign if_grant = !rst && if_valid && !d_grant;
    assign if_ready = if_grant;
    assign d_ready  = d_grant;

    mem_align_check u_align (
        .addr_lo    (d_grant ? d_addr[1:0] : if_addr[1:0]),
        .size       (d_size),
        .is_fetch   (!d_grant),
        .misaligned (misaligned)
    );

    assign bad_req = (if_grant || d_grant) && misaligned;

    always_comb begin
        mem_addr     = '0;
        mem_size     = 2'b00;
        mem_wdata    = 32'd0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        if (if_grant) begin
            mem_addr    = if_addr;
            mem_size    = SIZE_WORD;
            mem_read_en = !misaligned;
        end else if (d_grant) begin
            mem_addr     = d_addr;
            mem_size     = d_size;
            mem_wdata    = d_wdata;
            mem_read_en  = !d_we && !misaligned;
            mem_write_en = d_we && !misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
            is_write_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            if (if_grant)     owner <= OWN_IF;
            else if (d_grant) owner <= OWN_D;
            else              owner <= OWN_NONE;
            is_write_q <= d_grant && d_we;
            fault_q    <= bad_req;
            if (!if_valid || if_grant) begin
                starve_cnt <= 4'd0;
            end else if (d_grant && starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // A locally faulted request never reached memory, so its read data is meaningless.
    always_comb begin
        if_rsp_valid = (owner == OWN_IF) && !if_flush && !rst;
        d_rsp_valid  = (owner == OWN_D) && !rst;
        if_rsp_fault = if_rsp_valid && (fault_q || mem_fault);
        d_rsp_fault  = d_rsp_valid && (fault_q || mem_fault);
        if_rsp_data  = (if_rsp_valid && !fault_q) ? mem_rdata : 32'd0;
        d_rsp_data   = (d_rsp_valid && !fault_q && !is_write_q) ? mem_rdata : 32'd0;
    end

endmodule
